// File: rtl/vga_scan_fetch.sv
// vga_scan_fetch: 640x480@60 VGA raster scan fetching a 128x96 1-bit-per-colour image upscaled x5.
// The pixel clock is a /4 phase of clk; BRAM address leads the registered colour/sync by one pixel.
module vga_scan_fetch #(
    parameter int H_VISIBLE = 640,
    parameter int H_FP      = 16,
    parameter int H_SYNC    = 96,
    parameter int H_BP      = 48,
    parameter int V_VISIBLE = 480,
    parameter int V_FP      = 10,
    parameter int V_SYNC    = 2,
    parameter int V_BP      = 33,
    parameter int SCALE     = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        red_clr,
    input  logic        green_clr,
    input  logic        blue_clr,
    output logic [13:0] pxl_addr,
    output logic [3:0]  vga_red,
    output logic [3:0]  vga_green,
    output logic [3:0]  vga_blue,
    output logic        hsync,
    output logic        vsync,
    output logic        frame_start
);
    localparam int H_TOTAL = H_VISIBLE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_VISIBLE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);
    localparam logic [9:0] H_VIS  = 10'(H_VISIBLE);
    localparam logic [9:0] V_VIS  = 10'(V_VISIBLE);
    localparam logic [9:0] HS_BEG = 10'(H_VISIBLE + H_FP);
    localparam logic [9:0] HS_END = 10'(H_VISIBLE + H_FP + H_SYNC - 1);
    localparam logic [9:0] VS_BEG = 10'(V_VISIBLE + V_FP);
    localparam logic [9:0] VS_END = 10'(V_VISIBLE + V_FP + V_SYNC - 1);
    localparam logic [2:0] S_LAST = 3'(SCALE - 1);

    logic [1:0] ph;
    logic [9:0] hcount, vcount, hcount_n, vcount_n;
    logic [2:0] hsub, vsub, hsub_n, vsub_n;
    logic [6:0] hcol, vrow, hcol_n, vrow_n;
    logic       pix_edge, h_wrap, v_wrap, vis, vis_n;

    // Sub-pixel counters replace division by SCALE; hcol/vrow may run past the image in blanking, where the address is gated.
    always_comb begin
        pix_edge = ph == 2'd3;
        h_wrap   = hcount == H_LAST;
        v_wrap   = vcount == V_LAST;
        hcount_n = h_wrap ? '0 : hcount + 10'd1;
        hsub_n   = (h_wrap || hsub == S_LAST) ? '0 : hsub + 3'd1;
        hcol_n   = h_wrap ? '0 : (hsub == S_LAST ? hcol + 7'd1 : hcol);
        vcount_n = !h_wrap ? vcount : (v_wrap ? '0 : vcount + 10'd1);
        vsub_n   = !h_wrap ? vsub : ((v_wrap || vsub == S_LAST) ? '0 : vsub + 3'd1);
        vrow_n   = !h_wrap ? vrow : (v_wrap ? '0 : (vsub == S_LAST ? vrow + 7'd1 : vrow));
        vis      = hcount < H_VIS && vcount < V_VIS;
        vis_n    = hcount_n < H_VIS && vcount_n < V_VIS;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ph          <= '0;
            hcount      <= '0;
            vcount      <= '0;
            hsub        <= '0;
            vsub        <= '0;
            hcol        <= '0;
            vrow        <= '0;
            pxl_addr    <= '0;
            vga_red     <= '0;
            vga_green   <= '0;
            vga_blue    <= '0;
            hsync       <= 1'b1;
            vsync       <= 1'b1;
            frame_start <= 1'b0;
        end else begin
            ph          <= ph + 2'd1;
            frame_start <= pix_edge && h_wrap && v_wrap;
            if (pix_edge) begin
                hcount    <= hcount_n;
                vcount    <= vcount_n;
                hsub      <= hsub_n;
                vsub      <= vsub_n;
                hcol      <= hcol_n;
                vrow      <= vrow_n;
                pxl_addr  <= vis_n ? {vrow_n, hcol_n} : '0;
                vga_red   <= vis ? {4{red_clr}} : 4'h0;
                vga_green <= vis ? {4{green_clr}} : 4'h0;
                vga_blue  <= vis ? {4{blue_clr}} : 4'h0;
                hsync     <= !(hcount >= HS_BEG && hcount <= HS_END);
                vsync     <= !(vcount >= VS_BEG && vcount <= VS_END);
            end
        end
    end
endmodule

// File: tb/tb_vga_scan_fetch.sv
// tb_vga_scan_fetch: randomized-image check of vga_scan_fetch against an edge-count pixel model.
// Vertical timing is shortened so a whole frame fits a short run; horizontal timing is the real 800-pixel line.
module tb_vga_scan_fetch;
    localparam int HV = 640, HFP = 16, HS = 96, HBP = 48, HT = HV + HFP + HS + HBP;
    localparam int VV = 10, VFP = 2, VS = 2, VBP = 3, VT = VV + VFP + VS + VBP;
    localparam int SC = 5;
    localparam int FRAME_CLK = 4 * HT * VT;

    logic        clk = 1'b0;
    logic        reset;
    logic        red_clr, green_clr, blue_clr;
    logic [13:0] pxl_addr;
    logic [3:0]  vga_red, vga_green, vga_blue;
    logic        hsync, vsync, frame_start;

    bit mem_r [16384];
    bit mem_g [16384];
    bit mem_b [16384];

    int n_checks = 0;
    int n_fail   = 0;
    int cur_n    = 0;

    vga_scan_fetch #(
        .V_VISIBLE(VV), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP)
    ) dut (
        .clk(clk), .reset(reset),
        .red_clr(red_clr), .green_clr(green_clr), .blue_clr(blue_clr),
        .pxl_addr(pxl_addr),
        .vga_red(vga_red), .vga_green(vga_green), .vga_blue(vga_blue),
        .hsync(hsync), .vsync(vsync), .frame_start(frame_start)
    );

    always #5 clk = ~clk;

    // One-clock-latency BRAM model
    always @(posedge clk) begin
        red_clr   <= mem_r[pxl_addr];
        green_clr <= mem_g[pxl_addr];
        blue_clr  <= mem_b[pxl_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            if (n_fail <= 25)
                $display("FAIL %s at edge %0d: got %0h expected %0h", tag, cur_n, got, exp);
        end
    endtask

    function automatic int hpos(int k); return k % HT; endfunction
    function automatic int vpos(int k); return (k / HT) % VT; endfunction
    function automatic bit visible(int k); return hpos(k) < HV && vpos(k) < VV; endfunction
    function automatic int addr_of(int k);
        return visible(k) ? (vpos(k) / SC) * 128 + hpos(k) / SC : 0;
    endfunction

    // Compare all outputs after clock edge n (counted from reset release) with the pixel model.
    task automatic model_check(input int n);
        int p, k, a, hs_exp, vs_exp;
        logic [3:0] r, g, b;
        p = n / 4;
        k = p - 1;
        cur_n = n;
        check("pxl_addr", 32'(pxl_addr), 32'(addr_of(p)));
        if (k < 0) begin
            r = 4'h0; g = 4'h0; b = 4'h0; hs_exp = 1; vs_exp = 1;
        end else begin
            a = addr_of(k);
            r = visible(k) ? {4{mem_r[a]}} : 4'h0;
            g = visible(k) ? {4{mem_g[a]}} : 4'h0;
            b = visible(k) ? {4{mem_b[a]}} : 4'h0;
            hs_exp = (hpos(k) >= HV + HFP && hpos(k) < HV + HFP + HS) ? 0 : 1;
            vs_exp = (vpos(k) >= VV + VFP && vpos(k) < VV + VFP + VS) ? 0 : 1;
        end
        check("vga_red", 32'(vga_red), 32'(r));
        check("vga_green", 32'(vga_green), 32'(g));
        check("vga_blue", 32'(vga_blue), 32'(b));
        check("hsync", 32'(hsync), 32'(hs_exp));
        check("vsync", 32'(vsync), 32'(vs_exp));
        check("frame_start", 32'(frame_start), (n % 4 == 0 && p % (HT * VT) == 0) ? 32'd1 : 32'd0);
    endtask

    // Spot checks at the edges the timing description singles out.
    task automatic directed_check(input int n);
        if (n == 2627) check("hs_before_fall", 32'(hsync), 32'd1);
        if (n == 2628) check("hs_fall", 32'(hsync), 32'd0);
        if (n == 3011) check("hs_before_rise", 32'(hsync), 32'd0);
        if (n == 3012) check("hs_rise", 32'(hsync), 32'd1);
        if (n == 4)    check("addr_0_0", 32'(pxl_addr), 32'd0);
        if (n == 16)   check("addr_4_0", 32'(pxl_addr), 32'd0);
        if (n == 20)   check("addr_5_0", 32'(pxl_addr), 32'd1);
        if (n == 4 * 639) check("addr_639_0", 32'(pxl_addr), 32'd127);
        if (n == 4 * 640) check("addr_blank", 32'(pxl_addr), 32'd0);
        if (n == 4 * 5 * HT) check("addr_0_5", 32'(pxl_addr), 32'd128);
        if (n == 4 * ((VV - 1) * HT + 639)) check("addr_last", 32'(pxl_addr), 32'd255);
        if (n >= 4 && n <= 4 * 640 && n % 20 == 0)
            check("stripe", 32'(vga_red), ((n / 4 - 1) / 5) % 2 == 1 ? 32'hF : 32'h0);
        if (n == FRAME_CLK - 1) check("fs_before", 32'(frame_start), 32'd0);
        if (n == FRAME_CLK)     check("fs_pulse", 32'(frame_start), 32'd1);
        if (n == FRAME_CLK + 1) check("fs_after", 32'(frame_start), 32'd0);
    endtask

    task automatic run_edges(input int last);
        for (int n = 1; n <= last; n++) begin
            @(posedge clk);
            #1;
            model_check(n);
            directed_check(n);
        end
    endtask

    task automatic check_reset_state(input string tag);
        cur_n = 0;
        check({tag, "_addr"}, 32'(pxl_addr), 32'd0);
        check({tag, "_rgb"}, 32'({vga_red, vga_green, vga_blue}), 32'd0);
        check({tag, "_hsync"}, 32'(hsync), 32'd1);
        check({tag, "_vsync"}, 32'(vsync), 32'd1);
        check({tag, "_fs"}, 32'(frame_start), 32'd0);
    endtask

    initial begin
        // Random image; row 0 alternates by address bit 0 to give a visible 5-pixel stripe pattern.
        for (int a = 0; a < 16384; a++) begin
            mem_r[a] = a < 128 ? a[0] : 1'($urandom);
            mem_g[a] = 1'($urandom);
            mem_b[a] = 1'($urandom);
        end
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check_reset_state("reset");
        reset = 1'b0;
        run_edges(FRAME_CLK + 8);
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        run_edges(2699);
        check("mid_hsync_low", 32'(hsync), 32'd0);
        reset = 1'b1;
        @(posedge clk);
        #1;
        check_reset_state("mid_reset");
        reset = 1'b0;
        run_edges(3100);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
